// File: rtl/soc_test_monitor_pkg.sv
// Shared types and helpers for the end-of-test monitor.
//   mon_state_e : monitor FSM state encoding
//   ch_lsb()    : bit offset of channel c inside a packed per-channel bus
package soc_test_monitor_pkg;

   typedef enum logic [1:0] {
      MON_IDLE  = 2'd0,
      MON_RUN   = 2'd1,
      MON_DRAIN = 2'd2,
      MON_DONE  = 2'd3
   } mon_state_e;

   // Channel c occupies [ch_lsb(c, w) +: w] of a packed bus of w-bit words.
   function automatic int unsigned ch_lsb(input int unsigned c, input int unsigned w);
      return c * w;
   endfunction

endpackage

// File: rtl/soc_test_monitor_ch.sv
// One mailbox channel: first-flag result capture plus stall (hang) detection.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   init_i           clears capture/hang/stall state and samples the current address
//   run_i            monitor is in RUN; state is frozen otherwise
//   en_i             channel is part of the latched mask
//   flag_i/result_i  mailbox flag and result words
//   addr_i           instruction address used for stall detection
//   stall_limit_i    stall cycles flagged as hang, 0 disables
//   captured_o       result has been captured
//   hang_o           sticky hang flag
//   result_o         captured result word
//   reported_c_o     captured-or-hung including this cycle's events (combinational)
module soc_test_monitor_ch
   import soc_test_monitor_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned STALL_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               init_i,
   input  logic               run_i,
   input  logic               en_i,
   input  logic [DATA_W-1:0]  flag_i,
   input  logic [DATA_W-1:0]  result_i,
   input  logic [DATA_W-1:0]  addr_i,
   input  logic [STALL_W-1:0] stall_limit_i,
   output logic               captured_o,
   output logic               hang_o,
   output logic [DATA_W-1:0]  result_o,
   output logic               reported_c_o
);

   logic               captured_q, captured_d;
   logic               hang_q, hang_d;
   logic [DATA_W-1:0]  result_q, result_d;
   logic [DATA_W-1:0]  prev_addr_q, prev_addr_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               pending_c;

   // Capture on first non-zero flag; otherwise count cycles of a frozen address.
   always_comb begin
      captured_d  = captured_q;
      hang_d      = hang_q;
      result_d    = result_q;
      prev_addr_d = prev_addr_q;
      stall_d     = stall_q;
      pending_c   = en_i && !captured_q && !hang_q;

      if (init_i) begin
         captured_d  = 1'b0;
         hang_d      = 1'b0;
         result_d    = '0;
         stall_d     = '0;
         prev_addr_d = addr_i;
      end else if (run_i) begin
         prev_addr_d = addr_i;
         if (pending_c && (flag_i != '0)) begin
            captured_d = 1'b1;
            result_d   = result_i;
         end else if (pending_c) begin
            if (addr_i != prev_addr_q) begin
               stall_d = '0;
            end else if (stall_q != '1) begin
               stall_d = stall_q + STALL_W'(1);
            end
            if ((stall_limit_i != '0) && (stall_d == stall_limit_i)) begin
               hang_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         captured_q  <= 1'b0;
         hang_q      <= 1'b0;
         result_q    <= '0;
         prev_addr_q <= '0;
         stall_q     <= '0;
      end else begin
         captured_q  <= captured_d;
         hang_q      <= hang_d;
         result_q    <= result_d;
         prev_addr_q <= prev_addr_d;
         stall_q     <= stall_d;
      end
   end

   assign captured_o   = captured_q;
   assign hang_o       = hang_q;
   assign result_o     = result_q;
   assign reported_c_o = captured_d || hang_d;

endmodule

// File: rtl/soc_test_monitor.sv
// End-of-test monitor: waits for every masked channel to report (capture or hang),
// enforces a global cycle timeout, drains, then holds done/pass until cleared.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           level, leaves IDLE
//   clear_i           pulse, returns DONE to IDLE
//   ch_mask_i         channels that must report, sampled when leaving IDLE
//   timeout_i         RUN cycle limit, 0 = none
//   stall_limit_i     frozen-address cycles counted as hang, 0 = none
//   flag_i/result_i/addr_i  packed per-channel mailbox words
//   expected_i        golden result
//   done_o, pass_o    completion and verdict
//   timeout_o, hang_o sticky failure indicators
//   captured_o, result_o  per-channel capture flags and values
//   cycles_o          RUN cycle count
module soc_test_monitor
   import soc_test_monitor_pkg::*;
#(
   parameter int unsigned NUM_CH       = 3,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned CNT_W        = 20,
   parameter int unsigned STALL_W      = 8,
   parameter int unsigned DRAIN_CYCLES = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic                     clear_i,
   input  logic [NUM_CH-1:0]        ch_mask_i,
   input  logic [CNT_W-1:0]         timeout_i,
   input  logic [STALL_W-1:0]       stall_limit_i,
   input  logic [NUM_CH*DATA_W-1:0] flag_i,
   input  logic [NUM_CH*DATA_W-1:0] result_i,
   input  logic [NUM_CH*DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0]        expected_i,
   output logic                     done_o,
   output logic                     pass_o,
   output logic                     timeout_o,
   output logic [NUM_CH-1:0]        hang_o,
   output logic [NUM_CH-1:0]        captured_o,
   output logic [NUM_CH*DATA_W-1:0] result_o,
   output logic [CNT_W-1:0]         cycles_o
);

   // DRAIN lasts max(DRAIN_CYCLES, 1) cycles.
   localparam int unsigned DRN_W    = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
   localparam int unsigned DRN_LAST = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;

   mon_state_e        state_q, state_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]  cycles_q, cycles_d;
   logic [DRN_W-1:0]  drain_q, drain_d;
   logic              timeout_q, timeout_d;
   logic              init_c, run_c, all_rpt_c, res_ok_c;
   logic [NUM_CH-1:0] rpt_c;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      soc_test_monitor_ch #(
         .DATA_W  (DATA_W),
         .STALL_W (STALL_W)
      ) u_ch (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .init_i        (init_c),
         .run_i         (run_c),
         .en_i          (mask_q[c]),
         .flag_i        (flag_i[ch_lsb(c, DATA_W) +: DATA_W]),
         .result_i      (result_i[ch_lsb(c, DATA_W) +: DATA_W]),
         .addr_i        (addr_i[ch_lsb(c, DATA_W) +: DATA_W]),
         .stall_limit_i (stall_limit_i),
         .captured_o    (captured_o[c]),
         .hang_o        (hang_o[c]),
         .result_o      (result_o[ch_lsb(c, DATA_W) +: DATA_W]),
         .reported_c_o  (rpt_c[c])
      );
   end

   // Completion counts reports landing on this same edge.
   assign all_rpt_c = &(rpt_c | ~mask_q);

   // Next-state and counter control.
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      cycles_d  = cycles_q;
      drain_d   = drain_q;
      timeout_d = timeout_q;
      init_c    = 1'b0;
      run_c     = 1'b0;

      unique case (state_q)
         MON_IDLE: begin
            if (start_i) begin
               init_c    = 1'b1;
               mask_d    = ch_mask_i;
               cycles_d  = '0;
               drain_d   = '0;
               timeout_d = 1'b0;
               state_d   = (ch_mask_i == '0) ? MON_DRAIN : MON_RUN;
            end
         end
         MON_RUN: begin
            run_c = 1'b1;
            if (cycles_q != '1) begin
               cycles_d = cycles_q + CNT_W'(1);
            end
            // Timeout wins over a simultaneous completion.
            if ((timeout_i != '0) && (cycles_q == timeout_i - CNT_W'(1))) begin
               timeout_d = 1'b1;
               state_d   = MON_DONE;
            end else if (all_rpt_c) begin
               state_d = MON_DRAIN;
            end
         end
         MON_DRAIN: begin
            if (drain_q == DRN_W'(DRN_LAST)) begin
               state_d = MON_DONE;
            end else begin
               drain_d = drain_q + DRN_W'(1);
            end
         end
         MON_DONE: begin
            if (clear_i) begin
               init_c    = 1'b1;
               mask_d    = '0;
               cycles_d  = '0;
               drain_d   = '0;
               timeout_d = 1'b0;
               state_d   = MON_IDLE;
            end
         end
         default: state_d = MON_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= MON_IDLE;
         mask_q    <= '0;
         cycles_q  <= '0;
         drain_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         cycles_q  <= cycles_d;
         drain_q   <= drain_d;
         timeout_q <= timeout_d;
      end
   end

   // Every masked channel captured the golden value (hence all mutually equal).
   always_comb begin
      res_ok_c = 1'b1;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (mask_q[c] && (!captured_o[c] ||
             (result_o[ch_lsb(c, DATA_W) +: DATA_W] != expected_i))) begin
            res_ok_c = 1'b0;
         end
      end
   end

   assign done_o    = (state_q == MON_DONE);
   assign pass_o    = done_o && !timeout_q && (hang_o == '0) && res_ok_c;
   assign timeout_o = timeout_q;
   assign cycles_o  = cycles_q;

endmodule

// File: tb/tb_soc_test_monitor.sv
module tb_soc_test_monitor;

   localparam int DRN     = 1;
   localparam int DRN_EFF = (DRN == 0) ? 1 : DRN;
   localparam logic [31:0] EXP = 32'd42;

   typedef struct packed {
      int          done_k;
      logic        pass;
      logic        tmo;
      logic [2:0]  hang;
      logic [2:0]  cap;
      logic [95:0] res;
      logic [19:0] cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_i, start_i, clear_i;
   logic [2:0]  ch_mask_i;
   logic [19:0] timeout_i;
   logic [7:0]  stall_limit_i;
   logic [95:0] flag_i, result_i, addr_i;
   logic [31:0] expected_i;
   logic        done_o, pass_o, timeout_o;
   logic [2:0]  hang_o, captured_o;
   logic [95:0] result_o;
   logic [19:0] cycles_o;

   int          fc[3];
   logic [31:0] rv[3];
   logic [2:0]  frz;
   int          clr_k;
   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        sb_q[$];

   soc_test_monitor #(
      .NUM_CH(3), .DATA_W(32), .CNT_W(20), .STALL_W(8), .DRAIN_CYCLES(DRN)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
      .ch_mask_i(ch_mask_i), .timeout_i(timeout_i), .stall_limit_i(stall_limit_i),
      .flag_i(flag_i), .result_i(result_i), .addr_i(addr_i), .expected_i(expected_i),
      .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o), .hang_o(hang_o),
      .captured_o(captured_o), .result_o(result_o), .cycles_o(cycles_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Inputs for RUN cycle k (k=0 is the cycle before the start edge).
   task automatic drive(input int k);
      for (int c = 0; c < 3; c++) begin
         flag_i[c*32 +: 32]   = (fc[c] != 0 && k >= fc[c]) ? 32'd1 : 32'd0;
         result_i[c*32 +: 32] = (fc[c] != 0 && k > fc[c] + 2) ? 32'hDEAD_BEEF : rv[c];
         addr_i[c*32 +: 32]   = frz[c] ? 32'h100 : 32'h1000 + 32'(4 * k);
      end
      clear_i = (clr_k != 0 && k == clr_k);
   endtask

   // Reference model: when each channel reports, and what the monitor ends up showing.
   function automatic exp_t model(input logic [2:0] m, input int t, input int s);
      exp_t e;
      int   r, lim;
      bit   cap_ok[3], hg[3];
      int   rc[3];
      e = '0;
      r = 0;
      for (int c = 0; c < 3; c++) begin
         cap_ok[c] = m[c] && fc[c] != 0 && (!frz[c] || s == 0 || fc[c] <= s);
         hg[c]     = m[c] && !cap_ok[c] && frz[c] && s != 0;
         rc[c]     = cap_ok[c] ? fc[c] : (hg[c] ? s : (m[c] ? (1 << 30) : 0));
         if (rc[c] > r) r = rc[c];
      end
      if (t != 0 && t <= r) begin
         e.tmo = 1'b1; lim = t; e.done_k = t;
      end else begin
         lim = r; e.done_k = r + DRN_EFF;
      end
      e.cyc  = 20'(lim);
      e.pass = !e.tmo;
      for (int c = 0; c < 3; c++) begin
         if (m[c]) begin
            if (cap_ok[c] && fc[c] <= lim) begin
               e.cap[c] = 1'b1;
               e.res[c*32 +: 32] = rv[c];
               if (rv[c] != EXP) e.pass = 1'b0;
            end else begin
               e.pass = 1'b0;
            end
            if (hg[c] && s <= lim) e.hang[c] = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic run_scn(input string tag, input logic [2:0] m, input int t, input int s);
      exp_t e;
      int   n;
      sb_q.push_back(model(m, t, s));
      ch_mask_i = m; timeout_i = 20'(t); stall_limit_i = 8'(s);
      drive(0);
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i   = 1'b0;
      ch_mask_i = ~m;                       // must have been latched already
      drive(1);
      n = 0;
      while (!done_o && n < 2000) begin
         @(posedge clk); #1;
         n++;
         drive(n + 1);
      end
      clear_i = 1'b0;
      e = sb_q.pop_front();
      chk({tag, "/done_cycle"}, 128'(n), 128'(e.done_k));
      chk({tag, "/pass"},       128'(pass_o),     128'(e.pass));
      chk({tag, "/timeout"},    128'(timeout_o),  128'(e.tmo));
      chk({tag, "/hang"},       128'(hang_o),     128'(e.hang));
      chk({tag, "/captured"},   128'(captured_o), 128'(e.cap));
      chk({tag, "/result"},     128'(result_o),   128'(e.res));
      chk({tag, "/cycles"},     128'(cycles_o),   128'(e.cyc));
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "/hold"}, 128'({done_o, pass_o, cycles_o}), 128'({1'b1, e.pass, e.cyc}));
      clear_i = 1'b1;
      @(posedge clk); #1;
      clear_i = 1'b0;
      chk({tag, "/cleared"}, 128'({done_o, timeout_o, hang_o, captured_o, cycles_o, result_o}), 128'(0));
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; clear_i = 1'b0; ch_mask_i = 3'b111;
      timeout_i = '0; stall_limit_i = '0; expected_i = EXP;
      fc = '{0, 0, 0}; rv = '{EXP, EXP, EXP}; frz = 3'b000; clr_k = 0;
      drive(0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset", 128'({done_o, pass_o, timeout_o, hang_o, captured_o, cycles_o, result_o}), 128'(0));
      rst_i = 1'b0;
      @(posedge clk); #1;

      // Nominal run, with a clear pulse during RUN that must be ignored.
      fc = '{50, 50, 50}; rv = '{EXP, EXP, EXP}; frz = 3'b000; clr_k = 5;
      run_scn("nominal", 3'b111, 0, 0);
      clr_k = 0;

      // Channel 1 reports a wrong value.
      fc = '{20, 20, 20}; rv = '{EXP, 32'd41, EXP};
      run_scn("mismatch", 3'b111, 1000, 0);

      // Nobody reports: global timeout, DRAIN skipped.
      fc = '{0, 0, 0}; rv = '{EXP, EXP, EXP};
      run_scn("timeout", 3'b111, 100, 0);

      // Channel 2 address frozen.
      fc = '{5, 5, 0}; frz = 3'b100;
      run_scn("hang", 3'b111, 0, 16);
      frz = 3'b000;

      // Staggered captures with channel 1 unmasked; channel 0 result changes later.
      fc = '{10, 0, 30};
      run_scn("stagger", 3'b101, 0, 0);

      // Empty mask passes straight through DRAIN.
      fc = '{0, 0, 0};
      run_scn("nomask", 3'b000, 0, 0);

      // Timeout and completion on the same edge: timeout wins.
      fc = '{40, 40, 40};
      run_scn("tmo_vs_done", 3'b111, 40, 0);

      // Reset in the middle of a run.
      fc = '{10, 0, 0}; ch_mask_i = 3'b111; timeout_i = '0; stall_limit_i = '0;
      drive(0);
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         drive(k);
         @(posedge clk); #1;
      end
      chk("midrun/captured", 128'({done_o, captured_o, cycles_o}), 128'({1'b0, 3'b001, 20'd20}));
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      chk("midrun/reset", 128'({done_o, pass_o, timeout_o, hang_o, captured_o, cycles_o, result_o}), 128'(0));

      // Fresh run after reset starts from zeroed counters.
      fc = '{25, 12, 7}; rv = '{EXP, EXP, EXP};
      run_scn("after_reset", 3'b111, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/soc_test_monitor.md
Name: soc_test_monitor

Overview:
- Synthesisable end-of-test monitor for multi-core SoC runs; replaces bench-only flag polling and timeout logic with RTL usable in simulation and on FPGA.
- Watches NUM_CH mailbox channels (flag word + result word + instruction address per core/replica) and captures each result on its first non-zero flag.
- Detects per-channel hangs (instruction address frozen) and a global cycle timeout, then reports done/pass with a drain delay.

Parameters:
- NUM_CH, 3, number of monitored channels (e.g. TMR replicas); 1..8
- DATA_W, 32, width of flag, result, expected and address words
- CNT_W, 20, width of global cycle counter and timeout limit
- STALL_W, 8, width of per-channel stall counter
- DRAIN_CYCLES, 1, cycles waited after last capture before done_o (>=0)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  level; leaving IDLE requires start_i=1 (mirrors fetch enable)
- clear_i  in  1  pulse; returns DONE to IDLE, clears captures
- ch_mask_i  in  NUM_CH  channels that must report; sampled on IDLE->RUN
- timeout_i  in  CNT_W  cycle limit in RUN; 0 = no timeout
- stall_limit_i  in  STALL_W  cycles of unchanged address flagged as hang; 0 = disabled
- flag_i  in  NUM_CH*DATA_W  per-channel flag words, channel c at [c*DATA_W +: DATA_W]
- result_i  in  NUM_CH*DATA_W  per-channel result words
- addr_i  in  NUM_CH*DATA_W  per-channel instruction addresses
- expected_i  in  DATA_W  golden result
- done_o  out  1  in DONE state
- pass_o  out  1  valid when done_o: no timeout, no hang, all masked results == expected_i and mutually equal
- timeout_o  out  1  sticky timeout indicator
- hang_o  out  NUM_CH  sticky per-channel hang flags
- captured_o  out  NUM_CH  per-channel capture flags
- result_o  out  NUM_CH*DATA_W  captured results
- cycles_o  out  CNT_W  RUN cycle count, frozen outside RUN

Behaviour:
- Reset: state=IDLE; all outputs 0; latched mask 0.
- FSM IDLE -> RUN on start_i=1; latch ch_mask_i; zero counters, captures, sticky flags. ch_mask_i==0 -> DRAIN directly.
- RUN:
  - cycles_o increments every cycle, saturating at all-ones.
  - Channel c captures when masked, not yet captured, and flag word != 0: result_o[c] <= result_i[c], captured_o[c] <= 1 on the same edge. Later flag/result changes are ignored.
  - Several channels may capture on the same cycle.
  - Stall counter c resets to 0 when addr_i[c] changes and increments otherwise; only masked, uncaptured channels count. When it reaches stall_limit_i (non-zero), set hang_o[c]; the channel is then treated as reported with no capture.
  - Transition: all masked channels captured-or-hung -> DRAIN.
  - Timeout: timeout_i!=0 and cycles_o==timeout_i-1 at the edge -> timeout_o=1 and go to DONE, skipping DRAIN. Timeout takes priority over completion on the same cycle.
- DRAIN: counts DRAIN_CYCLES cycles (0 = one-cycle pass-through), then DONE. Captures and counters are frozen.
- DONE: done_o=1 and pass_o combinational from latched state; holds until clear_i -> IDLE. clear_i outside DONE is ignored.
- start_i dropping during RUN/DRAIN has no effect.
- rst_i at any time aborts to IDLE with reset values on the next edge.

Decomposition:
- Package soc_test_monitor_pkg:
  - state enum (MON_IDLE, MON_RUN, MON_DRAIN, MON_DONE)
  - slice helper function for channel c of a packed bus
- Sub-module soc_test_monitor_ch, instantiated NUM_CH times; holds capture register, capture flag, stall counter, previous address and hang flag.
- Top level holds the FSM, cycle counter, drain counter and pass reduction.

Test Plan:
- Nominal: NUM_CH=3, mask=111, expected=42; all three flags go to 1 at cycle 50 with result 42 -> captured=111, done_o at cycle 51+DRAIN_CYCLES, pass_o=1, cycles_o=50.
- Mismatch: channel 1 result 41, others 42 -> done_o=1, pass_o=0, result_o shows 41 in channel 1.
- Timeout: timeout_i=100, flags never rise -> timeout_o=1 and done_o after exactly 100 RUN cycles, pass_o=0, DRAIN skipped.
- Hang: stall_limit_i=16; channel 2 addr frozen, channels 0/1 report 42 -> hang_o=100, done_o=1, pass_o=0.
- Staggered/sticky: channel 0 flags at cycle 10 then result changes; channel 2 flags at cycle 30 -> channel 0 keeps its cycle-10 value; DRAIN entered at cycle 31.
- Reset/clear: rst_i mid-RUN -> all outputs 0 next cycle. clear_i in DONE -> IDLE; a new start_i run begins from zeroed counters.
